esm_entry_buffer: RTL and testbench

//  Entry storage stage directly upstream of the ESM shuffling core.
//  - Accepts payload words from the producer and stores each in the lowest-numbered free slot of a BS-entry buffer.
//  - Reports each newly filled slot index to the shuffling core (ready_index).
//  - Takes back the randomly chosen slot index (sel_index), moves that payload into a one-deep output register and frees the slot.
//  - Decouples in-order arrival from the randomised issue order.

---
 rtl/esm_entry_buffer_if.sv | 39 +++
 rtl/esm_entry_buffer.sv | 101 ++++++++++
 tb/tb_esm_entry_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/esm_entry_buffer_if.sv
// Bundle between the ESM entry buffer, its producer, the shuffling core and the consumer.
// The slave modport is the entry buffer; master is the environment driving it.
interface esm_entry_buffer_if #(
    parameter int BS = 16,
    parameter int DW = 32
);
    localparam int IW = $clog2(BS);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic [IW-1:0] ready_index;
    logic          ready_vld;

    logic          sel_valid;
    logic [IW-1:0] sel_index;
    logic          sel_ready;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;

    logic [IW:0]   count;
    logic          err_bad_sel;

    modport slave (
        input  in_valid, in_data, sel_valid, sel_index, out_ready,
        output in_ready, ready_index, ready_vld, sel_ready,
               out_valid, out_data, out_index, count, err_bad_sel
    );

    modport master (
        output in_valid, in_data, sel_valid, sel_index, out_ready,
        input  in_ready, ready_index, ready_vld, sel_ready,
               out_valid, out_data, out_index, count, err_bad_sel
    );
endinterface

// File: rtl/esm_entry_buffer.sv
// ESM entry buffer: in-order writes land in the lowest free slot, the shuffling
// core picks slots back out in random order through a one-deep output register.
module esm_entry_buffer #(
    parameter int BS = 16,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    esm_entry_buffer_if.slave     bus
);
    localparam int IW = $clog2(BS);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e    out_state_q;
    logic [BS-1:0] occ_q, occ_d;
    logic [IW:0]   count_q, count_d;
    logic [DW-1:0] mem_q [BS];
    logic          ready_vld_q;
    logic [IW-1:0] ready_index_q;
    logic [DW-1:0] out_data_q;
    logic [IW-1:0] out_index_q;
    logic          err_q;

    logic [IW-1:0] free_idx;
    logic          in_ready;
    logic          sel_ready;
    logic          enq;
    logic          sel_fire;
    logic          sel_hit;
    logic          sel_miss;

    // Lowest-numbered free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int unsigned i = BS; i > 0; i--) begin
            if (!occ_q[i-1]) free_idx = IW'(i - 1);
        end
    end

    assign in_ready  = (count_q != (IW+1)'(BS));
    assign sel_ready = (out_state_q == OUT_EMPTY) | bus.out_ready;
    assign enq       = bus.in_valid & in_ready;
    assign sel_fire  = bus.sel_valid & sel_ready;
    // A slot being written this cycle is still unoccupied in occ_q, so it misses.
    assign sel_hit   = sel_fire &  occ_q[bus.sel_index];
    assign sel_miss  = sel_fire & ~occ_q[bus.sel_index];

    always_comb begin
        occ_d = occ_q;
        if (enq)     occ_d[free_idx]      = 1'b1;
        if (sel_hit) occ_d[bus.sel_index] = 1'b0;
        count_d = count_q + {{IW{1'b0}}, enq} - {{IW{1'b0}}, sel_hit};
    end

    // Payload RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enq) mem_q[free_idx] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q   <= OUT_EMPTY;
            occ_q         <= '0;
            count_q       <= '0;
            ready_vld_q   <= 1'b0;
            ready_index_q <= '0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            count_q     <= count_d;
            ready_vld_q <= enq;
            if (enq) ready_index_q <= free_idx;
            if (sel_miss) err_q <= 1'b1;
            if (sel_hit) begin
                out_data_q  <= mem_q[bus.sel_index];
                out_index_q <= bus.sel_index;
            end
            case (out_state_q)
                OUT_EMPTY: if (sel_hit) out_state_q <= OUT_FULL;
                OUT_FULL:  if (!sel_hit && bus.out_ready) out_state_q <= OUT_EMPTY;
                default:   out_state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.sel_ready   = sel_ready;
    assign bus.ready_vld   = ready_vld_q;
    assign bus.ready_index = ready_index_q;
    assign bus.out_valid   = (out_state_q == OUT_FULL);
    assign bus.out_data    = out_data_q;
    assign bus.out_index   = out_index_q;
    assign bus.count       = count_q;
    assign bus.err_bad_sel = err_q;
endmodule

// File: tb/tb_esm_entry_buffer.sv
// Scoreboard bench for esm_entry_buffer: a slot-occupancy model predicts allocation
// indices and issued payloads, which are queued and matched as the DUT produces them.
module tb_esm_entry_buffer;
    localparam int BS = 16;
    localparam int DW = 32;
    localparam int IW = $clog2(BS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    esm_entry_buffer_if #(.BS(BS), .DW(DW)) bus ();

    esm_entry_buffer #(.BS(BS), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    bit [BS-1:0]   m_occ;
    logic [DW-1:0] m_mem [BS];
    int unsigned   m_cnt;
    bit            m_ov;
    bit            m_err;

    int unsigned   rdy_q[$];
    logic [DW-1:0] exp_data_q[$];
    int unsigned   exp_idx_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int unsigned model_free();
        for (int unsigned i = 0; i < BS; i++) if (!m_occ[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_occ = '0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_err = 1'b0;
        rdy_q.delete();
        exp_data_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit sv,
                         input int unsigned si, input bit ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.sel_valid = sv;
        bus.sel_index = IW'(si);
        bus.out_ready = ordy;
    endtask

    // One clock: pre-edge handshake checks, model update at the edge, post-edge checks.
    task automatic step();
        bit enq, srdy, hit, miss;
        int unsigned slot, si;
        #1;
        srdy = !m_ov || bus.out_ready;
        enq  = bus.in_valid && (m_cnt != BS);
        slot = model_free();
        si   = int'(bus.sel_index);
        hit  = bus.sel_valid && srdy && m_occ[si];
        miss = bus.sel_valid && srdy && !m_occ[si];
        check_eq("in_ready", bus.in_ready, m_cnt != BS);
        check_eq("sel_ready", bus.sel_ready, srdy);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_data_q.size() == 0) check_eq("out_unexpected", 1, 0);
            else begin
                check_eq("out_data", bus.out_data, exp_data_q.pop_front());
                check_eq("out_index", bus.out_index, exp_idx_q.pop_front());
            end
        end
        @(posedge clk);
        if (hit) begin
            exp_data_q.push_back(m_mem[si]);
            exp_idx_q.push_back(si);
            m_occ[si] = 1'b0;
            m_ov = 1'b1;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (enq) begin
            m_mem[slot] = bus.in_data;
            m_occ[slot] = 1'b1;
            rdy_q.push_back(slot);
        end
        if (miss) m_err = 1'b1;
        m_cnt = m_cnt + (enq ? 1 : 0) - (hit ? 1 : 0);
        #1;
        check_eq("ready_vld", bus.ready_vld, enq);
        if (bus.ready_vld) begin
            if (rdy_q.size() == 0) check_eq("ready_unexpected", 1, 0);
            else check_eq("ready_index", bus.ready_index, rdy_q.pop_front());
        end
        check_eq("count", bus.count, m_cnt);
        check_eq("out_valid", bus.out_valid, m_ov);
        check_eq("err_bad_sel", bus.err_bad_sel, m_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"}, bus.count, 0);
        check_eq({tag, "_ready_vld"}, bus.ready_vld, 0);
        check_eq({tag, "_ready_index"}, bus.ready_index, 0);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"}, bus.out_data, 0);
        check_eq({tag, "_out_index"}, bus.out_index, 0);
        check_eq({tag, "_err"}, bus.err_bad_sel, 0);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic apply_reset();
        drive(0, '0, 0, 0, 1);
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned si;
        drive(0, '0, 0, 0, 1);
        model_reset();
        apply_reset();

        // Four writes fill slots 0..3
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1, 32'hA000_0000 + i, 0, 0, 1);
            step();
            check_eq("t1_slot", bus.ready_index, i);
        end
        drive(0, '0, 0, 0, 1);
        step();
        check_eq("t1_count", bus.count, 4);

        // Fill to BS, then a dropped write while full
        for (int unsigned i = 4; i < BS; i++) begin
            drive(1, 32'hB000_0000 + i, 0, 0, 1);
            step();
        end
        check_eq("t2_full_count", bus.count, BS);
        drive(1, 32'hDEAD_BEEF, 0, 0, 1);
        step();
        check_eq("t2_full_in_ready", bus.in_ready, 0);
        drive(0, '0, 1, 5, 1);
        step();
        check_eq("t2_in_ready_after_sel", bus.in_ready, 1);
        drive(1, 32'hC000_0005, 0, 0, 1);
        step();
        check_eq("t2_reuse_slot5", bus.ready_index, 5);

        // Hold the output register while the consumer stalls
        drive(0, '0, 1, 2, 0);
        step();
        check_eq("t3_out_index", bus.out_index, 2);
        check_eq("t3_out_valid", bus.out_valid, 1);
        drive(0, '0, 1, 3, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check_eq("t3_hold_data", bus.out_data, 32'hA000_0002);
        end
        drive(0, '0, 0, 0, 1);
        step();

        // Enqueue while freeing slot 0: write goes to slot 2, slot 0 reused after
        drive(1, 32'hE000_0000, 1, 0, 1);
        step();
        check_eq("t4_simul_slot", bus.ready_index, 2);
        check_eq("t4_simul_count", bus.count, BS - 1);
        drive(1, 32'hE000_0001, 0, 0, 1);
        step();
        check_eq("t4_reuse_slot0", bus.ready_index, 0);

        // Empty slot 9 selection is flagged and sticky
        drive(0, '0, 1, 9, 1);
        step();
        drive(0, '0, 0, 0, 1);
        step();
        drive(0, '0, 1, 9, 1);
        step();
        check_eq("t5_err", bus.err_bad_sel, 1);
        check_eq("t5_out_valid", bus.out_valid, 0);
        drive(0, '0, 0, 0, 1);
        step();
        check_eq("t5_err_sticky", bus.err_bad_sel, 1);

        // Async reset mid-burst with a held output
        drive(1, 32'hF000_0000, 1, 4, 0);
        step();
        check_eq("t6_pre_out_valid", bus.out_valid, 1);
        drive(1, 32'hF000_0001, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h1234_5678, 0, 0, 1);
        step();
        check_eq("t6_first_slot", bus.ready_index, 0);

        // Select at count 0 after a fresh reset
        apply_reset();
        drive(0, '0, 1, 0, 1);
        step();
        check_eq("t7_empty_sel_err", bus.err_bad_sel, 1);

        // Selecting the slot being written this cycle counts as unoccupied
        apply_reset();
        drive(1, 32'h5555_0000, 0, 0, 1);
        step();
        drive(1, 32'h5555_0001, 1, 1, 1);
        step();
        check_eq("t8_same_slot_err", bus.err_bad_sel, 1);
        check_eq("t8_same_slot_valid", bus.out_valid, 0);

        // Randomised traffic against the scoreboard
        apply_reset();
        for (int unsigned c = 0; c < 400; c++) begin
            si = $urandom_range(BS - 1);
            if (m_cnt > 0 && $urandom_range(3) != 0)
                while (!m_occ[si]) si = $urandom_range(BS - 1);
            drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), si,
                  1'($urandom_range(3) != 0));
            step();
        end
        drive(0, '0, 0, 0, 1);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
